// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into flags and queues key events.
// Events land in a show-ahead FIFO two cycles after the stop-bit edge; events are dropped when the FIFO is full.
module ps2_kbd_rx #(
    parameter int FIFO_BITS = 2,
    parameter int TIMEOUT   = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] dout,
    output logic       extended,
    output logic       released,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overflow
);
    localparam int DEPTH = 2 ** FIFO_BITS;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [FIFO_BITS:0] CNT_FULL = (FIFO_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic          ps2d_s1_q, ps2d_s2_q;
    logic          fall;
    logic          bit_in;

    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          ext_pend_q, rel_pend_q;
    logic          push_q;
    logic [9:0]    push_dat_q;
    logic          frame_err_q, parity_err_q;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= ps2_clk_in;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= ps2_data_in;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall   = ps2c_prev_q & ~ps2c_s2_q;
    assign bit_in = ps2d_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            ext_pend_q   <= 1'b0;
            rel_pend_q   <= 1'b0;
            push_q       <= 1'b0;
            push_dat_q   <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (state_q == S_IDLE) begin
                tmo_q <= '0;
                if (fall) begin
                    if (!bit_in) begin
                        state_q  <= S_DATA;
                        bitcnt_q <= '0;
                        shift_q  <= '0;
                    end else begin
                        frame_err_q <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        rel_pend_q  <= 1'b0;
                    end
                end
            end else if (!fall) begin
                if (tmo_q == TMO_LAST) begin
                    state_q     <= S_IDLE;
                    tmo_q       <= '0;
                    frame_err_q <= 1'b1;
                    ext_pend_q  <= 1'b0;
                    rel_pend_q  <= 1'b0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
                case (state_q)
                    S_DATA: begin
                        shift_q  <= {bit_in, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= bit_in;
                        state_q <= S_STOP;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        if (!bit_in) begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            rel_pend_q  <= 1'b0;
                        end else if (!(^{shift_q, par_q})) begin
                            parity_err_q <= 1'b1;
                            ext_pend_q   <= 1'b0;
                            rel_pend_q   <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_pend_q <= 1'b1;
                        end else begin
                            push_q     <= 1'b1;
                            push_dat_q <= {ext_pend_q, rel_pend_q, shift_q};
                            ext_pend_q <= 1'b0;
                            rel_pend_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    logic [9:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_BITS:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rd_en, wr_en, full;
    logic [9:0]           head;

    // A pop frees the slot in the same cycle, so a push into a full FIFO with rd still lands.
    always_comb begin
        full   = (cnt_q == CNT_FULL);
        rd_en  = rd && (cnt_q != '0);
        wr_en  = push_q && (!full || rd_en);
        cnt_d  = cnt_q;
        if (wr_en && !rd_en) cnt_d = cnt_q + 1'b1;
        else if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;
        wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
        ovf_d  = ovf_q | (push_q && full && !rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= push_dat_q;
    end

    assign head       = mem_q[rptr_q];
    assign valid      = (cnt_q != '0);
    assign dout       = valid ? head[7:0] : 8'h00;
    assign extended   = valid & head[9];
    assign released   = valid & head[8];
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of single frames plus timeout, overflow and reset sequences.
module tb_ps2_kbd_rx;
    localparam int TMO = 200;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       rd = 1'b0;
    logic       valid;
    logic [7:0] dout;
    logic       extended, released, frame_err, parity_err, overflow;

    int n_cmp = 0;
    int n_fail = 0;
    int ferr_pulses = 0, ferr_cycles = 0, perr_pulses = 0, perr_cycles = 0;
    logic ferr_prev = 1'b0, perr_prev = 1'b0;

    ps2_kbd_rx #(.FIFO_BITS(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .rd(rd), .valid(valid), .dout(dout), .extended(extended), .released(released),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cycles++;
        if (frame_err && !ferr_prev) ferr_pulses++;
        if (parity_err) perr_cycles++;
        if (parity_err && !perr_prev) perr_pulses++;
        ferr_prev = frame_err;
        perr_prev = parity_err;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic       push;
        logic [7:0] exp_dout;
        logic       exp_ext;
        logic       exp_rel;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                            input logic bad_stop);
        logic par;
        par = bad_par ? ^code : ~^code;
        return {~bad_stop, par, code, 1'b0};
    endfunction

    // Sends the first n bits of a frame, LSB first; data changes while the PS/2 clock is high.
    task automatic send_bits(input logic [10:0] bits, input int n, input logic rd_on_stop);
        for (int i = 0; i < n; i++) begin
            ps2_data_in = bits[i];
            repeat (HP) @(negedge clk);
            ps2_clk_in = 1'b0;
            if (rd_on_stop && i == 10) begin
                repeat (3) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                repeat (HP - 4) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code);
        send_bits(mk_frame(code, 1'b0, 1'b0), 11, 1'b0);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp_d, input logic exp_e,
                           input logic exp_r);
        chk({name, "_valid"}, {31'd0, valid}, 32'd1);
        chk({name, "_dout"}, {24'd0, dout}, {24'd0, exp_d});
        chk({name, "_ext"}, {31'd0, extended}, {31'd0, exp_e});
        chk({name, "_rel"}, {31'd0, released}, {31'd0, exp_r});
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        int f0, p0;
        vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 0, 0};
        vt[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vt[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vt[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 0, 0};
        vt[4]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 0, 0};
        vt[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
        vt[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vt[7]  = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 0, 0};
        vt[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vt[9]  = '{8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
        vt[10] = '{8'h29, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 0, 0};
        vt[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vt[12] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
        vt[13] = '{8'h4A, 1'b0, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0, 0, 0};

        repeat (5) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_flags", {29'd0, extended, released, overflow}, 32'd0);
        chk("rst_errs", {30'd0, frame_err, parity_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            f0 = ferr_pulses;
            p0 = perr_pulses;
            send_bits(mk_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop), 11, 1'b0);
            chk($sformatf("v%0d_ferr", i), ferr_pulses - f0, vt[i].exp_ferr);
            chk($sformatf("v%0d_perr", i), perr_pulses - p0, vt[i].exp_perr);
            if (vt[i].push) pop_chk($sformatf("v%0d", i), vt[i].exp_dout, vt[i].exp_ext,
                                    vt[i].exp_rel);
            chk($sformatf("v%0d_empty", i), {31'd0, valid}, 32'd0);
        end

        // Clock stalls after the 4th data bit until the frame is aborted.
        f0 = ferr_pulses;
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_ferr", ferr_pulses - f0, 1);
        chk("tmo_empty", {31'd0, valid}, 32'd0);
        send(8'h5A);
        pop_chk("tmo_next", 8'h5A, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'h11 + 8'(i), 1'b0, 1'b0);
        chk("ovf_drained", {31'd0, valid}, 32'd0);

        // Reset while the receiver sits in PARITY with a queued entry and sticky overflow.
        send(8'h21);
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 9, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_valid", {31'd0, valid}, 32'd0);
        chk("mid_dout", {24'd0, dout}, 32'd0);
        chk("mid_flags", {29'd0, extended, released, overflow}, 32'd0);
        chk("mid_errs", {30'd0, frame_err, parity_err}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h66);
        pop_chk("post_rst", 8'h66, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
        send_bits(mk_frame(8'h15, 1'b0, 1'b0), 11, 1'b1);
        chk("full_rd_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("full_rd_pop%0d", i), 8'h12 + 8'(i), 1'b0, 1'b0);
        chk("full_rd_empty", {31'd0, valid}, 32'd0);

        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        chk("rd_empty_valid", {31'd0, valid}, 32'd0);

        chk("ferr_width", ferr_cycles, ferr_pulses);
        chk("perr_width", perr_cycles, perr_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
